// File: rtl/cnn_pkg.sv
// Shared CNN datapath definitions: default lane geometry, counter width and the
// signed clamp helper reused by the quantisation stages.
package cnn_pkg;

    localparam int IW_DEF    = 24;
    localparam int DW_DEF    = 8;
    localparam int BW_DEF    = 16;
    localparam int DN_DEF    = 6;
    localparam int SAT_CNT_W = 16;

    typedef logic [SAT_CNT_W-1:0] sat_cnt_t;

    // Clamp to a w-bit signed range; the result stays sign-extended at 64 bits
    // so callers can detect clipping by comparing against the input.
    function automatic logic signed [63:0] sat_s(input logic signed [63:0] v,
                                                 input int unsigned w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (v > hi) begin
            return hi;
        end
        if (v < lo) begin
            return lo;
        end
        return v;
    endfunction

endpackage

// File: rtl/relu_quant_lane.sv
// One requantisation lane: bias add + half-up rounding offset (stage 1), then
// arithmetic shift, optional ReLU and clamp to the output width (stage 2).
module relu_quant_lane
    import cnn_pkg::*;
#(
    parameter int IW = IW_DEF,
    parameter int DW = DW_DEF,
    parameter int BW = BW_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_ld1,
    input  logic                 i_ld2,
    input  logic signed [IW-1:0] i_acc,
    input  logic signed [BW-1:0] i_bias,
    input  logic [4:0]           i_shift,
    input  logic                 i_relu_en,
    output logic signed [DW-1:0] o_q,
    output logic                 o_clip
);

    function automatic logic signed [IW+1:0] rnd_half(input logic [4:0] sh);
        logic signed [IW+1:0] r;
        r = '0;
        if (sh != 5'd0) begin
            r = {{(IW+1){1'b0}}, 1'b1} << (sh - 5'd1);
        end
        return r;
    endfunction

    logic signed [IW+1:0] w_sum_p0;
    logic signed [IW+1:0] r_sum_p1;
    logic signed [IW+1:0] w_y_p1;
    logic signed [IW+1:0] w_yr_p1;
    logic signed [63:0]   w_wide_p1;
    logic signed [63:0]   w_sat_p1;
    logic signed [DW-1:0] r_q_p2;

    assign w_sum_p0 = (IW+2)'(i_acc) + (IW+2)'(i_bias) + rnd_half(i_shift);

    // stage 1: biased, round-offset sum
    always_ff @(posedge clk) begin
        if (i_ld1) begin
            r_sum_p1 <= w_sum_p0;
        end
    end

    assign w_y_p1    = r_sum_p1 >>> i_shift;
    assign w_yr_p1   = (i_relu_en && w_y_p1[IW+1]) ? '0 : w_y_p1;
    assign w_wide_p1 = 64'(w_yr_p1);
    assign w_sat_p1  = sat_s(w_wide_p1, DW);
    assign o_clip    = (w_sat_p1 != w_wide_p1);

    // stage 2: quantised output register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_q_p2 <= '0;
        end else if (i_ld2) begin
            r_q_p2 <= w_sat_p1[DW-1:0];
        end
    end

    assign o_q = r_q_p2;

endmodule

// File: rtl/relu_quant.sv
// Requantisation stage feeding max_pool: DN lanes through a 2-stage valid/ready
// pipeline, plus a saturating count of clipped lanes.
module relu_quant
    import cnn_pkg::*;
#(
    parameter int IW = IW_DEF,
    parameter int DW = DW_DEF,
    parameter int BW = BW_DEF,
    parameter int DN = DN_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DN*IW-1:0]     m_data,
    input  logic                 m_valid,
    output logic                 m_ready,
    input  logic [DN*BW-1:0]     cfg_bias,
    input  logic [4:0]           cfg_shift,
    input  logic                 cfg_relu_en,
    input  logic                 cfg_clr,
    output logic [DN*DW-1:0]     s_data,
    output logic                 s_valid,
    input  logic                 s_ready,
    output logic                 busy,
    output logic [SAT_CNT_W-1:0] sat_cnt
);

    logic                 r_vld_p1;
    logic                 r_vld_p2;
    logic                 w_en1;
    logic                 w_en2;
    logic                 w_ld1;
    logic                 w_ld2;
    logic [DN-1:0]        w_clip;
    logic signed [DW-1:0] w_q [DN];
    sat_cnt_t             w_pop;
    logic [SAT_CNT_W:0]   w_cnt_next;
    sat_cnt_t             r_sat_cnt;

    // s_ready reaches m_ready combinationally so a full pipe can pop and accept in one cycle
    assign w_en2   = ~r_vld_p2 | s_ready;
    assign w_en1   = ~r_vld_p1 | w_en2;
    assign w_ld1   = w_en1 & m_valid;
    assign w_ld2   = w_en2 & r_vld_p1;
    assign m_ready = w_en1;

    // stage 1 / stage 2 valid flags
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld_p1 <= 1'b0;
            r_vld_p2 <= 1'b0;
        end else begin
            if (w_en1) begin
                r_vld_p1 <= m_valid;
            end
            if (w_en2) begin
                r_vld_p2 <= r_vld_p1;
            end
        end
    end

    for (genvar k = 0; k < DN; k++) begin : g_lane
        relu_quant_lane #(
            .IW(IW),
            .DW(DW),
            .BW(BW)
        ) u_lane (
            .clk       (clk),
            .rst       (rst),
            .i_ld1     (w_ld1),
            .i_ld2     (w_ld2),
            .i_acc     (m_data[k*IW +: IW]),
            .i_bias    (cfg_bias[k*BW +: BW]),
            .i_shift   (cfg_shift),
            .i_relu_en (cfg_relu_en),
            .o_q       (w_q[k]),
            .o_clip    (w_clip[k])
        );
        assign s_data[k*DW +: DW] = w_q[k];
    end

    always_comb begin
        w_pop = '0;
        for (int k = 0; k < DN; k++) begin
            w_pop = w_pop + SAT_CNT_W'(w_clip[k]);
        end
    end

    assign w_cnt_next = {1'b0, r_sat_cnt} + {1'b0, w_pop};

    // clip events are only counted as a beat lands in the output register
    always_ff @(posedge clk) begin
        if (rst || cfg_clr) begin
            r_sat_cnt <= '0;
        end else if (w_ld2) begin
            r_sat_cnt <= w_cnt_next[SAT_CNT_W] ? '1 : w_cnt_next[SAT_CNT_W-1:0];
        end
    end

    assign s_valid = r_vld_p2;
    assign busy    = r_vld_p1 | r_vld_p2;
    assign sat_cnt = r_sat_cnt;

endmodule

// File: tb/tb_relu_quant.sv
// Bench for relu_quant: arithmetic reference model with an in-order scoreboard,
// plus directed beats with hand-derived results.
module tb_relu_quant;

    localparam int IW = 24;
    localparam int DW = 8;
    localparam int BW = 16;
    localparam int DN = 6;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [DN*IW-1:0] m_data = '0;
    logic             m_valid = 1'b0;
    logic             m_ready;
    logic [DN*BW-1:0] cfg_bias = '0;
    logic [4:0]       cfg_shift = '0;
    logic             cfg_relu_en = 1'b0;
    logic             cfg_clr = 1'b0;
    logic [DN*DW-1:0] s_data;
    logic             s_valid;
    logic             s_ready = 1'b1;
    logic             busy;
    logic [15:0]      sat_cnt;

    relu_quant #(.IW(IW), .DW(DW), .BW(BW), .DN(DN)) dut (
        .clk         (clk),
        .rst         (rst),
        .m_data      (m_data),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .cfg_bias    (cfg_bias),
        .cfg_shift   (cfg_shift),
        .cfg_relu_en (cfg_relu_en),
        .cfg_clr     (cfg_clr),
        .s_data      (s_data),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .busy        (busy),
        .sat_cnt     (sat_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DN*DW-1:0] data;
        int               clips;
    } beat_t;

    int               checks = 0;
    int               failures = 0;
    beat_t            sb_q[$];
    beat_t            sb_b;
    int               model_cnt = 0;
    int               n_out = 0;
    logic [DN*DW-1:0] hold_data = '0;
    bit               stalled_prev = 1'b0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic fail_timeout(input string nm);
        checks++;
        failures++;
        $display("FAIL %s timeout actual=none required=event", nm);
    endtask

    // Expected output of one beat from plain integer arithmetic
    function automatic void model(input logic [DN*IW-1:0] d, output beat_t b);
        longint a, bi, s, y, hi, lo;
        int sh;
        sh = int'(cfg_shift);
        hi = (longint'(1) << (DW - 1)) - 1;
        lo = -(longint'(1) << (DW - 1));
        b.data = '0;
        b.clips = 0;
        for (int k = 0; k < DN; k++) begin
            a  = longint'($signed(d[k*IW +: IW]));
            bi = longint'($signed(cfg_bias[k*BW +: BW]));
            s  = a + bi;
            if (sh > 0) s = s + (longint'(1) << (sh - 1));
            y = s >>> sh;
            if (cfg_relu_en && y < 0) y = 0;
            if (y > hi) begin
                y = hi;
                b.clips++;
            end else if (y < lo) begin
                y = lo;
                b.clips++;
            end
            b.data[k*DW +: DW] = y[DW-1:0];
        end
    endfunction

    // Scoreboard: decisions at negedge reflect what the next rising edge transfers
    always @(negedge clk) begin
        if (rst) begin
            sb_q.delete();
            model_cnt = 0;
            stalled_prev = 1'b0;
        end else begin
            if (stalled_prev) begin
                check("hold_valid", 64'(s_valid), 64'd1);
                check("hold_data", 64'(s_data), 64'(hold_data));
            end
            stalled_prev = s_valid && !s_ready;
            hold_data = s_data;
            if (!busy) check("sat_cnt_model", 64'(sat_cnt), 64'(model_cnt));
            if (s_valid && s_ready) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_beat actual=%0h required=no_beat", s_data);
                end else begin
                    sb_b = sb_q.pop_front();
                    check("beat_data", 64'(s_data), 64'(sb_b.data));
                end
                n_out++;
            end
            if (cfg_clr) model_cnt = 0;
            if (m_valid && m_ready) begin
                model(m_data, sb_b);
                sb_q.push_back(sb_b);
                model_cnt = (model_cnt + sb_b.clips > 65535) ? 65535 : model_cnt + sb_b.clips;
            end
        end
    end

    task automatic set_all(input logic signed [IW-1:0] acc);
        for (int k = 0; k < DN; k++) m_data[k*IW +: IW] = acc;
    endtask

    task automatic set_cfg(input int sh, input bit relu);
        cfg_shift = sh[4:0];
        cfg_relu_en = relu;
        cfg_bias = '0;
    endtask

    task automatic wait_out(input string nm);
        int n = 0;
        while (!s_valid && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        if (!s_valid) fail_timeout(nm);
    endtask

    task automatic wait_idle(input string nm);
        int n = 0;
        while (busy && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (busy) fail_timeout(nm);
    endtask

    // Present one beat held until accepted (m_ready sampled at negedge)
    task automatic send(input logic signed [IW-1:0] acc, input string nm);
        int  t = 0;
        bit  ok = 1'b0;
        set_all(acc);
        m_valid = 1'b1;
        while (!ok && t < 20) begin
            @(negedge clk);
            ok = m_ready;
            @(posedge clk); #1;
            t++;
        end
        m_valid = 1'b0;
        if (!ok) fail_timeout(nm);
    endtask

    task automatic lit(input string nm, input logic signed [IW-1:0] acc, input logic [DW-1:0] e);
        send(acc, nm);
        wait_out(nm);
        check(nm, 64'(s_data), 64'({DN{e}}));
        @(posedge clk); #1;
        wait_idle(nm);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DN*DW-1:0] exp_v;
        int               out0;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_s_valid", 64'(s_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_sat_cnt", 64'(sat_cnt), 64'd0);
        check("rst_s_data", 64'(s_data), 64'd0);
        check("rst_m_ready", 64'(m_ready), 64'd1);

        set_cfg(4, 1'b1);
        lit("rnd_48", 48, 8'h03);
        lit("rnd_40", 40, 8'h03);
        lit("relu_m40", -40, 8'h00);
        check("relu_sat_cnt", 64'(sat_cnt), 64'd0);

        set_cfg(0, 1'b0);
        lit("sh0_5", 5, 8'h05);
        set_cfg(1, 1'b0);
        lit("sh1_3", 3, 8'h02);
        lit("sh1_m3", -3, 8'hFF);

        set_cfg(4, 1'b0);
        lit("sat_pos", 24'h010000, 8'h7F);
        check("sat_cnt_6", 64'(sat_cnt), 64'd6);
        lit("sat_neg", -24'sh010000, 8'h80);
        check("sat_cnt_12", 64'(sat_cnt), 64'd12);
        cfg_clr = 1'b1;
        @(posedge clk); #1 cfg_clr = 1'b0;
        check("clr_sat_cnt", 64'(sat_cnt), 64'd0);

        set_cfg(0, 1'b0);
        cfg_bias[0*BW +: BW] = -16'sd16;
        cfg_bias[1*BW +: BW] = 16'sd5;
        set_all(7);
        m_data[0*IW +: IW] = 24'd16;
        m_data[1*IW +: IW] = 24'd10;
        m_valid = 1'b1;
        @(posedge clk); #1 m_valid = 1'b0;
        wait_out("bias");
        exp_v = {DN{8'h07}};
        exp_v[0*DW +: DW] = 8'h00;
        exp_v[1*DW +: DW] = 8'h0F;
        check("bias_lanes", 64'(s_data), 64'(exp_v));
        @(posedge clk); #1;
        wait_idle("bias");
        cfg_bias = '0;

        out0 = n_out;
        fork
            begin
                for (int i = 0; i < 8; i++) send(IW'(i + 1), "bp_send");
            end
            begin
                repeat (3) @(posedge clk);
                #1 s_ready = 1'b0;
                @(negedge clk);
                check("bp_m_ready_full", 64'(m_ready), 64'd0);
                check("bp_busy_full", 64'(s_valid & busy), 64'd1);
                repeat (3) @(posedge clk);
                #1 s_ready = 1'b1;
            end
        join
        wait_idle("bp");
        check("bp_out_count", 64'(n_out - out0), 64'd8);
        check("bp_queue_empty", 64'(sb_q.size()), 64'd0);

        s_ready = 1'b0;
        send(24'd3, "rst_a");
        send(24'd4, "rst_b");
        check("rst_inflight", 64'(busy & s_valid), 64'd1);
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        check("mid_rst_s_valid", 64'(s_valid), 64'd0);
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_sat_cnt", 64'(sat_cnt), 64'd0);
        s_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check("no_stale", 64'(s_valid), 64'd0);
        end
        set_all(9);
        m_valid = 1'b1;
        @(posedge clk); #1 m_valid = 1'b0;
        check("lat_edge_n", 64'(s_valid), 64'd0);
        @(posedge clk); #1;
        check("lat_edge_n1", 64'(s_valid), 64'd1);
        check("lat_data", 64'(s_data), 64'({DN{8'h09}}));
        @(posedge clk); #1;
        wait_idle("lat");

        set_cfg(4, 1'b0);
        set_all(24'h010000);
        m_valid = 1'b1;
        repeat (10923) @(posedge clk);
        #1 m_valid = 1'b0;
        wait_idle("sticky");
        check("sat_cnt_sticky", 64'(sat_cnt), 64'hFFFF);
        cfg_clr = 1'b1;
        @(posedge clk); #1 cfg_clr = 1'b0;
        check("sticky_clr", 64'(sat_cnt), 64'd0);

        @(posedge clk); #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/relu_quant.md
# relu_quant

Requantisation stage directly upstream of `max_pool` in the CNN datapath. It takes DN lanes of wide signed accumulator results from the convolution array and adds a per-lane bias. It then rounds, arithmetically right-shifts, optionally applies ReLU and saturates each lane to a DW-bit signed value. The result drives `max_pool`'s `m_data`/`m_valid`. The block is a 2-stage valid/ready pipeline with full throughput and a saturation event counter.

## Interface
- `IW`, 24: accumulator lane width (signed), 8..32
- `DW`, 8: output lane width (signed)
- `BW`, 16: bias lane width (signed)
- `DN`, 6: lanes per beat
- `clk`  in  1  clock; all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `m_data`  in  DN*IW  accumulator lanes; lane k at [k*IW +: IW]
- `m_valid`  in  1  input beat valid
- `m_ready`  out  1  input beat accepted when `m_valid & m_ready`
- `cfg_bias`  in  DN*BW  per-lane signed bias
- `cfg_shift`  in  5  right-shift amount, 0..IW-1
- `cfg_relu_en`  in  1  clamp negatives to 0
- `cfg_clr`  in  1  clear `sat_cnt` (synchronous)
- `s_data`  out  DN*DW  quantised lanes, to `max_pool` `m_data`
- `s_valid`  out  1  output beat valid
- `s_ready`  in  1  downstream accept; tie to 1 when feeding `max_pool`
- `busy`  out  1  any pipeline stage holds a beat
- `sat_cnt`  out  16  count of clipped lanes, saturating

## Operation
- Stage 1 on accept computes per lane `sum = acc + sext(bias)` at IW+1 bits. If shift>0 it then adds `1<<(shift-1)`, giving IW+2 bits. This is round-half-up.
- Stage 2 computes `y = sum >>> shift` (arithmetic).
  - If `cfg_relu_en` and y<0, y=0.
  - Else clamp y to [-2^(DW-1), 2^(DW-1)-1].
  - Register the result into `s_data`.
- Clip event: a lane whose post-ReLU y is outside the DW range. ReLU zeroing is not a clip.
- `sat_cnt` increments by the popcount of clipped lanes on each stage-2 load and sticks at 0xFFFF.
  - `cfg_clr` has priority over an increment in the same cycle. The result is 0, and that cycle's events are dropped.
- Config is quasi-static. It changes only while `busy`=0, and behaviour on a change while `busy`=1 is undefined.
  - Bias and relu are used at stage 1 and stage 2 respectively without being captured per beat.
- The block never drops or duplicates a beat, and output order equals input order.

## Timing
- Enables: `en2 = ~s_valid | s_ready`; `en1 = ~v1 | en2`; `m_ready = en1`. This is a combinational path from `s_ready` to `m_ready`.
- Latency: a beat accepted at edge N gives `s_valid`=1 with its data after edge N+1, and it is visible from cycle N+2.
- Throughput is 1 beat/cycle while `s_ready`=1.
- Backpressure with `s_ready`=0:
  - `s_data`/`s_valid` hold stable.
  - Stage 1 fills, then `m_ready`=0.
  - At most 2 beats are held.
- A simultaneous output pop and input accept on a full pipeline proceed in the same cycle, with no bubble.
- Reset values: `s_valid`=0, `v1`=0, `s_data`=0, `sat_cnt`=0, `busy`=0.
  - `m_ready`=1 from the first cycle after reset.
- Reset mid-stream discards in-flight beats; none are emitted afterwards.
- `busy = v1 | s_valid`.

## Structure
- Shared package `cnn_pkg`: `IW/DW/BW/DN` defaults, `SAT_CNT_W=16`, and a `sat_s` clamp function reused by later quant stages.
- One sub-module, `relu_quant_lane`, holds the per-lane arithmetic (stage 1 and stage 2 datapath plus the clip flag) and is instanced DN times.
- The top level holds the valid/ready control, the popcount and `sat_cnt`.

## Test plan
- Rounding and ReLU. Setup: shift=4, bias=0, relu=1, all lanes.
  - acc=48 -> 0x03.
  - acc=40 -> 0x03.
  - acc=-40 -> 0x00.
  - `sat_cnt` stays 0 throughout.
- Shift edge cases. Setup: shift=0, acc=5 -> 0x05.
  - shift=1, acc=3 -> 0x02.
  - shift=1, acc=-3 -> 0xFF (-1).
  - relu=0.
- Saturation. Setup: shift=4.
  - acc=0x010000 -> 0x7F in all lanes, and `sat_cnt`=6.
  - relu=0, acc=-0x010000 -> 0x80, and `sat_cnt`=12.
  - `cfg_clr` pulse -> 0.
- Bias. Setup: shift=0.
  - Lane0 bias=-16, acc=16 -> 0x00.
  - Lane1 bias=5, acc=10 -> 0x0F.
  - Other lanes bias=0 pass acc through.
- Backpressure: stream 8 incrementing beats and drop `s_ready` for 3 cycles mid-stream.
  - `s_data` holds stable while stalled.
  - `m_ready`=0 once 2 beats are held.
  - All 8 beats emerge in order with no duplicates.
- Reset mid-stream: assert `rst` with 2 beats in flight.
  - Next cycle `s_valid`=0, `busy`=0 and `sat_cnt`=0.
  - No stale beat appears afterwards.
  - A fresh beat has 2-cycle latency.
